// File: rtl/vga_fbram_if.sv
// Bus bundle for vga_fbram: user write port, scan-out read port,
// fill engine control and status.
interface vga_fbram_if #(
    parameter int DW = 12,
    parameter int AW = 14
);
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          fill_start;
    logic [DW-1:0] fill_data;
    logic          fill_busy;
    logic          fill_done;
    logic          wr_drop;

    modport master (
        output wen, waddr, wdata,
        output ren, raddr,
        output fill_start, fill_data,
        input  rdata, rvalid,
        input  fill_busy, fill_done, wr_drop
    );

    modport slave (
        input  wen, waddr, wdata,
        input  ren, raddr,
        input  fill_start, fill_data,
        output rdata, rvalid,
        output fill_busy, fill_done, wr_drop
    );
endinterface

// File: rtl/vga_fbram.sv
// Simple-dual-port framebuffer RAM with range guards, read-valid
// pipeline and a whole-buffer fill engine.
module vga_fbram #(
    parameter int DW     = 12,
    parameter int DEPTH  = 12288,
    parameter int AW     = 14,
    parameter int RD_LAT = 1
) (
    input logic        clk,
    input logic        rst,
    vga_fbram_if.slave bus
);
    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    (* ram_style = "block" *)
    logic [DW-1:0] ram [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] color_q, color_d;
    logic          done_q, done_d;
    logic          drop_q;
    logic          busy;
    logic          waddr_ok;
    logic          raddr_ok;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd_q;
    logic          v_q;

    assign busy     = (state_q == FILL);
    assign waddr_ok = {1'b0, bus.waddr} < DEPTH_X;
    assign raddr_ok = {1'b0, bus.raddr} < DEPTH_X;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            done_q  <= done_d;
            drop_q  <= bus.wen && (busy || !waddr_ok);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.fill_start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    color_d = bus.fill_data;
                end
            end
            FILL: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The fill engine owns the write port while busy.
    always_comb begin
        if (busy) begin
            we = 1'b1;
            wa = cnt_q;
            wd = color_q;
        end else begin
            we = bus.wen && waddr_ok;
            wa = bus.waddr;
            wd = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            ram[wa] <= wd;
        end
    end

    // Read-first: the read samples the array before this edge's write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
            v_q  <= 1'b0;
        end else begin
            v_q <= bus.ren;
            if (bus.ren) begin
                rd_q <= raddr_ok ? ram[bus.raddr] : '0;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] rd2_q;
            logic          v2_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd2_q <= '0;
                    v2_q  <= 1'b0;
                end else begin
                    rd2_q <= rd_q;
                    v2_q  <= v_q;
                end
            end
            assign bus.rdata  = rd2_q;
            assign bus.rvalid = v2_q;
        end else begin : g_lat1
            assign bus.rdata  = rd_q;
            assign bus.rvalid = v_q;
        end
    endgenerate

    assign bus.fill_busy = busy;
    assign bus.fill_done = done_q;
    assign bus.wr_drop   = drop_q;
endmodule

// File: tb/tb_vga_fbram.sv
// Bench for vga_fbram: vector table with read scoreboard, latency,
// fill and reset-abort sequences.
module tb_vga_fbram;
    localparam int DEPTH = 12288;

    logic clk;
    logic rst;

    vga_fbram_if #(.DW(12), .AW(14)) b1 ();
    vga_fbram_if #(.DW(12), .AW(14)) b2 ();

    vga_fbram #(.DW(12), .DEPTH(DEPTH), .AW(14), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    vga_fbram #(.DW(12), .DEPTH(DEPTH), .AW(14), .RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q [$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (b1.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_extra got=%0h want=none", b1.rdata);
            end else begin
                chk("rdata", 32'(b1.rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic        wen;
        logic [13:0] waddr;
        logic [11:0] wdata;
        logic        ren;
        logic [13:0] raddr;
        logic [11:0] exp_rd;
        logic        exp_drop;
    } vec_t;

    vec_t vt [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        b1.wen = 0; b1.ren = 0; b1.fill_start = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic rd(input int a, input logic [11:0] e);
        b1.ren = 1; b1.raddr = 14'(a);
        exp_q.push_back(e);
        tick();
        b1.ren = 0;
    endtask

    task automatic do_fill(input logic [11:0] c, input bit poke);
        int nbusy = 0;
        int ndone = 0;
        int dpos  = 0;
        b1.fill_start = 1; b1.fill_data = c;
        for (int i = 1; i <= 12300; i++) begin
            tick();
            if (b1.fill_busy) nbusy++;
            if (b1.fill_done) begin
                ndone++;
                dpos = i;
            end
            b1.fill_start = 0;
            if (poke && i == 50) begin
                b1.wen = 1; b1.waddr = 3; b1.wdata = 12'hEEE;
                b1.fill_start = 1; b1.fill_data = 12'hF00;
            end
            if (poke && i == 51) begin
                b1.wen = 0;
                chk("busy_drop", 32'(b1.wr_drop), 1);
            end
            if (poke && i == 52) chk("busy_drop_end", 32'(b1.wr_drop), 0);
        end
        chk("busy_cycles", nbusy, DEPTH);
        chk("done_pulses", ndone, 1);
        chk("done_pos", dpos, DEPTH + 1);
    endtask

    initial begin
        rst = 1;
        b1.wen = 0; b1.waddr = 0; b1.wdata = 0; b1.ren = 0; b1.raddr = 0;
        b1.fill_start = 0; b1.fill_data = 0;
        b2.wen = 0; b2.waddr = 0; b2.wdata = 0; b2.ren = 0; b2.raddr = 0;
        b2.fill_start = 0; b2.fill_data = 0;

        vt[0]  = '{1, 14'd5,     12'hABC, 0, 14'd0,     12'h000, 0};
        vt[1]  = '{1, 14'd12287, 12'h123, 0, 14'd0,     12'h000, 0};
        vt[2]  = '{0, 14'd0,     12'h000, 1, 14'd5,     12'hABC, 0};
        vt[3]  = '{0, 14'd0,     12'h000, 1, 14'd12287, 12'h123, 0};
        vt[4]  = '{1, 14'd12288, 12'hFFF, 0, 14'd0,     12'h000, 1};
        vt[5]  = '{0, 14'd0,     12'h000, 1, 14'd16000, 12'h000, 0};
        vt[6]  = '{1, 14'd7,     12'h111, 0, 14'd0,     12'h000, 0};
        vt[7]  = '{1, 14'd7,     12'h222, 1, 14'd7,     12'h111, 0};
        vt[8]  = '{0, 14'd0,     12'h000, 1, 14'd7,     12'h222, 0};
        vt[9]  = '{1, 14'd20,    12'h555, 1, 14'd5,     12'hABC, 0};
        vt[10] = '{1, 14'd16383, 12'h777, 1, 14'd20,    12'h555, 1};
        vt[11] = '{0, 14'd0,     12'h000, 1, 14'd12288, 12'h000, 0};
        vt[12] = '{0, 14'd0,     12'h000, 1, 14'd5,     12'hABC, 0};

        #2;
        chk("rst_rdata", 32'(b1.rdata), 0);
        chk("rst_rvalid", 32'(b1.rvalid), 0);
        chk("rst_busy", 32'(b1.fill_busy), 0);
        chk("rst_done", 32'(b1.fill_done), 0);
        chk("rst_drop", 32'(b1.wr_drop), 0);
        chk("rst_rdata2", 32'(b2.rdata), 0);
        tick();
        rst = 0;
        tick();

        for (int i = 0; i < 13; i++) begin
            b1.wen = vt[i].wen; b1.waddr = vt[i].waddr;
            b1.wdata = vt[i].wdata;
            b1.ren = vt[i].ren; b1.raddr = vt[i].raddr;
            if (vt[i].ren) exp_q.push_back(vt[i].exp_rd);
            tick();
            chk($sformatf("drop%0d", i), 32'(b1.wr_drop),
                32'(vt[i].exp_drop));
        end
        idle1();
        rd(12287, 12'h123);
        drain();
        tick();
        chk("hold_rdata", 32'(b1.rdata), 32'h123);
        chk("hold_rvalid", 32'(b1.rvalid), 0);

        // RD_LAT=2 instance
        b2.wen = 1; b2.waddr = 5; b2.wdata = 12'hABC;
        tick();
        b2.wen = 0;
        tick();
        b2.ren = 1; b2.raddr = 5;
        tick();
        b2.ren = 0;
        chk("lat2_v1", 32'(b2.rvalid), 0);
        chk("lat2_d1", 32'(b2.rdata), 0);
        tick();
        chk("lat2_v2", 32'(b2.rvalid), 1);
        chk("lat2_d2", 32'(b2.rdata), 32'hABC);
        tick();
        chk("lat2_v3", 32'(b2.rvalid), 0);

        do_fill(12'h0F0, 1);
        idle1();
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            b1.ren = 1; b1.raddr = 14'(a);
            exp_q.push_back(12'h0F0);
            tick();
        end
        b1.ren = 0;
        drain();

        b1.fill_start = 1; b1.fill_data = 12'hA5A;
        for (int i = 1; i <= 101; i++) begin
            tick();
            b1.fill_start = 0;
        end
        rst = 1;
        #1;
        chk("abort_rdata", 32'(b1.rdata), 0);
        chk("abort_rvalid", 32'(b1.rvalid), 0);
        chk("abort_busy", 32'(b1.fill_busy), 0);
        chk("abort_done", 32'(b1.fill_done), 0);
        chk("abort_drop", 32'(b1.wr_drop), 0);
        tick();
        rst = 0;
        tick();
        chk("abort_idle", 32'(b1.fill_busy), 0);
        rd(0, 12'hA5A);
        rd(99, 12'hA5A);
        rd(100, 12'h0F0);
        rd(101, 12'h0F0);
        rd(12287, 12'h0F0);
        drain();

        do_fill(12'h333, 0);
        idle1();
        tick();
        rd(0, 12'h333);
        rd(100, 12'h333);
        rd(12287, 12'h333);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_fbram.md
Name: vga_fbram

Overview:
- Parametrised simple-dual-port framebuffer RAM for the VGA/HDMI pixel path.
  - Write port is driven by the game/render logic.
  - Read port is driven by the scan-out timing generator.
- Generalises the fixed 12-bit/12288-entry video RAM in three ways:
  - configurable width, depth and read latency (1 or 2);
  - a read-valid output;
  - an out-of-range address guard.
- Adds a built-in fill engine that clears or paints the whole buffer with one colour without CPU/game-logic involvement.

Parameters:
- DW, 12: pixel data width in bits (12 = RGB444).
- DEPTH, 12288: number of entries; need not be a power of two.
- AW, 14: address width; must satisfy 2^AW >= DEPTH.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2 (2 adds an output register for timing closure).

Ports:
- clk, in, 1: single system/pixel clock; all logic rising-edge.
- rst, in, 1: asynchronous, active-high reset.
- wen, in, 1: user write enable.
- waddr, in, AW: user write address.
- wdata, in, DW: user write data.
- ren, in, 1: read enable.
- raddr, in, AW: read address.
- rdata, out, DW: read data.
- rvalid, out, 1: rdata carries the result of a read issued RD_LAT cycles earlier.
- fill_start, in, 1: single-cycle request to fill the whole RAM.
- fill_data, in, DW: fill colour, sampled on the accepted fill_start cycle.
- fill_busy, out, 1: fill engine is running.
- fill_done, out, 1: one-cycle pulse after the last fill write.
- wr_drop, out, 1: one-cycle pulse when a user write was discarded.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - rdata=0, rvalid=0, fill_busy=0, fill_done=0, wr_drop=0;
  - fill FSM goes to IDLE, fill counter=0, internal pipeline registers=0;
  - RAM contents are NOT reset (block RAM inference; `ram_style="block"` attribute kept).
- Write port:
  - on clk with wen=1, fill_busy=0 and waddr<DEPTH, write wdata to ram[waddr];
  - waddr>=DEPTH: write discarded, wr_drop=1 next cycle;
  - wen=1 while fill_busy=1: write discarded, wr_drop=1 next cycle (fill owns the write port).
- Read port:
  - ren=1 at cycle N: the RAM stage registers ram[raddr], or 0 if raddr>=DEPTH;
  - RD_LAT=1: rdata valid at N+1;
  - RD_LAT=2: a second, always-enabled register presents it at N+2;
  - rvalid = ren delayed by exactly RD_LAT cycles, including for out-of-range reads;
  - ren=0: the RAM-stage register holds its value; with RD_LAT=1, rdata holds its last value.
- Read/write collision (same address, same cycle, from user or fill): read-first; rdata returns the old contents.
- Reads remain fully functional during a fill; each location returns pre-fill or fill data according to read-first ordering relative to the fill counter.
- Fill FSM states IDLE, FILL:
  - IDLE -> FILL on fill_start=1: latch fill_data, counter=0, fill_busy=1 from the next cycle;
  - FILL: each cycle write latched colour to ram[counter], counter+1;
  - when counter==DEPTH-1, that write completes, the FSM returns to IDLE, fill_busy drops and fill_done=1 for one cycle in the same next cycle;
  - total: DEPTH write cycles, fill_busy high for exactly DEPTH cycles.
- fill_start while fill_busy=1: ignored; no restart, colour unchanged.
- fill_start coinciding with wen in IDLE:
  - the user write is performed (fill not yet busy);
  - the fill then overwrites that location when the counter reaches it.
- rst asserted mid-fill:
  - fill aborts immediately, no fill_done;
  - RAM holds a partial fill;
  - a new fill_start after reset restarts from address 0.
- Counter width is AW; it never exceeds DEPTH-1.

Test Plan:
- Write/read, DW=12, DEPTH=12288, RD_LAT=1: write 0xABC@5 and 0x123@12287; ren raddr=5 -> rdata=0xABC and rvalid=1 one cycle later; raddr=12287 -> 0x123.
- Latency and hold: RD_LAT=2, ren at cycle 10 for addr 5 -> rvalid=1 and rdata=0xABC at cycle 12 only. RD_LAT=1 with ren low afterwards -> rdata holds 0xABC, rvalid=0.
- Out-of-range: wen waddr=12288 data 0xFFF -> wr_drop=1 for one cycle and no RAM change. ren raddr=16000 -> rdata=0, rvalid=1.
- Collision: ram[7]=0x111; same cycle wen waddr=7 wdata=0x222 and ren raddr=7 -> rdata=0x111. Re-read -> 0x222.
- Fill: fill_start with fill_data=0x0F0 -> fill_busy high exactly 12288 cycles, fill_done one pulse, all addresses read 0x0F0. wen during busy -> wr_drop pulses, data still 0x0F0. Second fill_start during busy -> completion time unchanged.
- Reset mid-fill: assert rst after 100 fill cycles -> outputs 0 immediately. Addresses 0..99 hold the fill colour, addresses >=100 hold old data. New fill completes normally.
